// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int NFLAGS    = 3;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its top bit for overflow.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    c_msb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub with accumulate, flags and valid/ready handshakes.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
  end

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    opa_q, opb_q, res_q, res_d;
  logic                carry_q;
  logic [CW-1:0]       cnt_q;
  logic [NFLAGS-1:0]   flags_q;
  logic [DIGIT-1:0]    dsum;
  logic                dcout, dcmsb;
  logic                accept, last;

  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == LAST);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign cout      = flags_q[FLAG_COUT];
  assign ovf       = flags_q[FLAG_OVF];
  assign zero      = flags_q[FLAG_ZERO];

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (opa_q[cnt_q*DIGIT +: DIGIT]),
    .b     (opb_q[cnt_q*DIGIT +: DIGIT]),
    .cin   (carry_q),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full result as it will stand after this cycle's digit is written; zero flag uses it on the last digit.
  always_comb begin
    res_d = res_q;
    res_d[cnt_q*DIGIT +: DIGIT] = dsum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          opa_q   <= acc ? res_q : a;
          opb_q   <= b ^ {WIDTH{sub}};
          carry_q <= sub;
          cnt_q   <= '0;
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= dcout;
          if (last) begin
            flags_q[FLAG_COUT] <= dcout;
            flags_q[FLAG_OVF]  <= dcmsb ^ dcout;
            flags_q[FLAG_ZERO] <= (res_d == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: three instances (DIGIT=4, 1, 16) checked against a scoreboard model.
module tb_addsub_serial;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid, out_ready;
  logic [15:0] a, b;
  logic        sub, acc;
  logic        in_ready [3];
  logic        out_valid[3];
  logic [15:0] res_w    [3];
  logic        cout_w   [3];
  logic        ovf_w    [3];
  logic        zero_w   [3];

  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          t0;
  int          lat_of[3] = '{4, 16, 1};
  logic [15:0] model_acc[3];
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .sub(sub), .acc(acc), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(res_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]));

  addsub_serial #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .sub(sub), .acc(acc), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(res_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]));

  addsub_serial #(.WIDTH(16), .DIGIT(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .sub(sub), .acc(acc), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(res_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain 17-bit arithmetic, carry into MSB recovered from the MSB sum bit.
  function automatic exp_t model(input logic [15:0] opa, input logic [15:0] bv, input logic s);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] s17;
    logic        c15;
    bb     = bv ^ {16{s}};
    s17    = {1'b0, opa} + {1'b0, bb} + {16'd0, s};
    e.res  = s17[15:0];
    e.cout = s17[16];
    c15    = opa[15] ^ bb[15] ^ s17[15];
    e.ovf  = c15 ^ s17[16];
    e.zero = (s17[15:0] == 16'd0);
    return e;
  endfunction

  task automatic drive(input int u, input logic [15:0] av, input logic [15:0] bv,
                       input logic s, input logic ac);
    exp_t e;
    a = av; b = bv; sub = s; acc = ac;
    in_valid[u] = 1'b1;
    e = model(ac ? model_acc[u] : av, bv, s);
    model_acc[u] = e.res;
    sb.push_back(e);
  endtask

  task automatic accept_wait(input int u);
    int n = 0;
    while (in_ready[u] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("in_ready_wait", {31'd0, in_ready[u]}, 32'd1);
    @(negedge clk);
    in_valid[u] = 1'b0;
    t0 = cyc;
  endtask

  task automatic collect(input int u, input string tag);
    int   n = 0;
    exp_t e;
    while (out_valid[u] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_out_valid"}, {31'd0, out_valid[u]}, 32'd1);
    check({tag, "_latency"}, cyc - t0, lat_of[u]);
    check({tag, "_sb_depth"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, {16'd0, res_w[u]}, {16'd0, e.res});
      check({tag, "_cout"}, {31'd0, cout_w[u]}, {31'd0, e.cout});
      check({tag, "_ovf"}, {31'd0, ovf_w[u]}, {31'd0, e.ovf});
      check({tag, "_zero"}, {31'd0, zero_w[u]}, {31'd0, e.zero});
    end
    if (out_ready[u]) begin
      @(negedge clk);
      check({tag, "_out_valid_drop"}, {31'd0, out_valid[u]}, 32'd0);
      check({tag, "_in_ready_back"}, {31'd0, in_ready[u]}, 32'd1);
    end
  endtask

  task automatic op(input int u, input string tag, input logic [15:0] av, input logic [15:0] bv,
                    input logic s, input logic ac);
    drive(u, av, bv, s, ac);
    accept_wait(u);
    collect(u, tag);
  endtask

  initial begin
    logic [15:0] held;
    logic        held_cout;
    rst_n = 1'b0; in_valid = '0; out_ready = '1;
    a = '0; b = '0; sub = 1'b0; acc = 1'b0;
    for (int i = 0; i < 3; i++) model_acc[i] = '0;
    repeat (2) @(negedge clk);

    // Reset state
    for (int u = 0; u < 3; u++) begin
      check("rst_in_ready", {31'd0, in_ready[u]}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid[u]}, 32'd0);
      check("rst_result", {16'd0, res_w[u]}, 32'd0);
      check("rst_flags", {29'd0, cout_w[u], ovf_w[u], zero_w[u]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add/sub and boundary flags
    op(0, "add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("t1_literal", {16'd0, res_w[0]}, 32'h2233);
    op(0, "sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b0);
    check("t2_literal", {16'd0, res_w[0]}, 32'hFFFE);
    op(0, "sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0);
    check("t2b_flags", {30'd0, cout_w[0], ovf_w[0]}, 32'd3);
    op(0, "add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("t3_flags", {29'd0, cout_w[0], ovf_w[0], zero_w[0]}, 32'b101);
    op(0, "add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("t3b_literal", {15'd0, ovf_w[0], res_w[0]}, 32'h18000);

    // Accumulate from a fresh reset; operand a must be ignored
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) model_acc[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, "acc_add1", 16'hDEAD, 16'd5, 1'b0, 1'b1);
    op(0, "acc_add2", 16'hBEEF, 16'd5, 1'b0, 1'b1);
    op(0, "acc_add3", 16'hDEAD, 16'd5, 1'b0, 1'b1);
    check("t4_literal", {16'd0, res_w[0]}, 32'd15);
    op(0, "acc_sub15", 16'hBEEF, 16'd15, 1'b1, 1'b1);
    check("t4_zero_cout", {30'd0, zero_w[0], cout_w[0]}, 32'd3);

    // Backpressure in DONE with a new request already waiting
    out_ready[0] = 1'b0;
    drive(0, 16'h4321, 16'h1111, 1'b0, 1'b0);
    accept_wait(0);
    collect(0, "bp_first");
    held = res_w[0];
    held_cout = cout_w[0];
    drive(0, 16'h0100, 16'h0023, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
      check("bp_result_stable", {16'd0, res_w[0]}, {16'd0, held});
      check("bp_cout_stable", {31'd0, cout_w[0]}, {31'd0, held_cout});
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_released_valid", {31'd0, out_valid[0]}, 32'd0);
    check("bp_released_ready", {31'd0, in_ready[0]}, 32'd1);
    accept_wait(0);
    check("bp_accept_first_idle", {31'd0, in_ready[0]}, 32'd0);
    collect(0, "bp_second");

    // Reset during the second RUN cycle discards the operation
    drive(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    accept_wait(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("midrun_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("midrun_result", {16'd0, res_w[0]}, 32'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    for (int i = 0; i < 3; i++) model_acc[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Same operation at DIGIT=1 and DIGIT=16
    op(1, "d1_add", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("d1_literal", {16'd0, res_w[1]}, 32'h2233);
    op(2, "d16_add", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("d16_literal", {16'd0, res_w[2]}, 32'h2233);
    op(1, "d1_sub", 16'h8000, 16'h0001, 1'b1, 1'b0);
    op(2, "d16_sub", 16'h8000, 16'h0001, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
Parametrised, digit-serial two's-complement adder/subtractor with accumulate mode, status flags and valid/ready handshakes on input and output. It processes DIGIT bits per clock over WIDTH/DIGIT cycles, trading latency for area. It sits in the datapath as the arithmetic unit behind register-file or stream sources and feeds downstream consumers that may stall.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT; violation is an elaboration error.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, cycles per operation.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand request valid.
in_ready  out  1  unit can accept; high only in IDLE.
a  in  WIDTH  operand A; ignored when acc=1.
b  in  WIDTH  operand B.
sub  in  1  0 = A+B, 1 = A-B (B inverted, carry-in 1).
acc  in  1  1 = use internal accumulator in place of a.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  sum/difference; also the accumulator.
cout  out  1  carry out of MSB; for sub, 1 = no borrow (A >= B unsigned).
ovf  out  1  signed overflow (carry into MSB XOR carry out).
zero  out  1  result == 0.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, result/accumulator=0, cout=ovf=zero=0, digit counter=0.
- States IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge E0: latch opA = acc ? result : a; opB = b XOR {WIDTH{sub}}; carry = sub; counter=0; go RUN.
- RUN: each cycle add digit[counter] of opA, opB and carry; write DIGIT sum bits into result position counter (LSB digit first); update carry; counter++. On the last digit (counter==NDIG-1): capture cout=final carry, ovf=carry into MSB XOR final carry, go DONE.
- DONE: out_valid=1; result, flags stable until out_ready. On out_valid&&out_ready: out_valid=0, go IDLE. result retained as accumulator.
- Latency: out_valid rises at edge E0+NDIG. in_ready low through RUN and DONE; in_valid there is ignored, no queuing. Best-case throughput one op per NDIG+2 cycles.
- zero computed on full result in DONE.
- result during RUN is partially updated; only meaningful with out_valid=1.
- Reset mid-RUN or mid-DONE: operation discarded, all state as reset, accumulator cleared.
- NDIG=1 (DIGIT=WIDTH): RUN lasts one cycle; same protocol.
- Counter width clog2(NDIG), minimum 1 bit; no wrap past NDIG-1.

Decomposition:
- Package addsub_pkg: state enum (IDLE, RUN, DONE), flag-bit index constants.
- Sub-module addsub_digit: combinational DIGIT-bit adder slice (a, b, cin -> sum, cout, carry into top bit), instantiated once; FSM, counter and shift/store in top.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
1. Add 0x1234+0x0FFF, sub=0 -> result 0x2233, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
2. Sub 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
3. Add 0xFFFF+0x0001 -> 0x0000, cout=1, zero=1, ovf=0; add 0x7FFF+0x0001 -> 0x8000, ovf=1.
4. Accumulate from reset: acc=1 add b=5 three times -> 5, 10, 15; then acc=1 sub b=15 -> 0, zero=1, cout=1.
5. Backpressure: out_ready low 3 cycles in DONE with in_valid held high -> result/flags stable, in_ready=0, no new op accepted; accept occurs in the first IDLE cycle after out handshake.
6. rst_n low during 2nd RUN cycle -> out_valid=0, in_ready=1, result=0 immediately; then rerun test 1 with DIGIT=1 (16-cycle latency) and DIGIT=16 (1-cycle latency), identical results.
